// File: rtl/sp_ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port RAM.
// Ports: m0_*/m1_* master req/gnt/rsp, ram_* RAM side, mN_gnt_cnt_o.
module sp_ram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  output logic [15:0]             m0_gnt_cnt_o,
  output logic [15:0]             m1_gnt_cnt_o
);

  logic        last_m1;
  logic        gnt0;
  logic        gnt1;
  logic        rsp_valid;
  logic        rsp_owner;
  logic        rsp_write;
  logic [15:0] cnt0;
  logic [15:0] cnt1;

  // m1 wins a tie unless it was the last one served
  assign gnt1 = m1_req_i & (~m0_req_i | ~last_m1);
  assign gnt0 = m0_req_i & ~gnt1;

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  always_comb begin
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    unique case (1'b1)
      gnt0: begin
        ram_en_o    = 1'b1;
        ram_addr_o  = m0_addr_i;
        ram_wdata_o = m0_wdata_i;
        ram_we_o    = m0_we_i;
        ram_be_o    = m0_be_i;
      end
      gnt1: begin
        ram_en_o    = 1'b1;
        ram_addr_o  = m1_addr_i;
        ram_wdata_o = m1_wdata_i;
        ram_we_o    = m1_we_i;
        ram_be_o    = m1_be_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rsp_valid <= 1'b0;
      rsp_owner <= 1'b0;
      rsp_write <= 1'b0;
      last_m1   <= 1'b0;
      cnt0      <= '0;
      cnt1      <= '0;
    end else begin
      rsp_valid <= gnt0 | gnt1;
      rsp_owner <= gnt1;
      rsp_write <= ram_we_o;
      if (gnt0 | gnt1)
        last_m1 <= gnt1;
      if (gnt0 && cnt0 != 16'hFFFF)
        cnt0 <= cnt0 + 16'd1;
      if (gnt1 && cnt1 != 16'hFFFF)
        cnt1 <= cnt1 + 16'd1;
    end
  end

  assign m0_rvalid_o = rsp_valid & ~rsp_owner;
  assign m1_rvalid_o = rsp_valid & rsp_owner;

  // write responses carry no data
  assign m0_rdata_o =
    (m0_rvalid_o & ~rsp_write) ? ram_rdata_i : '0;
  assign m1_rdata_o =
    (m1_rvalid_o & ~rsp_write) ? ram_rdata_i : '0;

  assign m0_gnt_cnt_o = cnt0;
  assign m1_gnt_cnt_o = cnt1;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter with a byte-enabled RAM model.
// Ports: drives both masters, models the registered RAM read port.
module tb_sp_ram_arbiter;

  typedef struct {
    bit          own;
    bit          wr;
    logic [31:0] data;
  } rsp_t;

  logic        clk;
  logic        rstn;
  logic        req   [2];
  logic        we    [2];
  logic [14:0] addr  [2];
  logic [3:0]  be    [2];
  logic [31:0] wd    [2];
  logic        nreq  [2];
  logic        nwe   [2];
  logic [14:0] naddr [2];
  logic [3:0]  nbe   [2];
  logic [31:0] nwd   [2];

  logic        m0_gnt, m1_gnt;
  logic        m0_rv, m1_rv;
  logic [31:0] m0_rd, m1_rd;
  logic        ram_en, ram_we;
  logic [14:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata;
  logic [15:0] cnt0, cnt1;

  logic [31:0] ram_mem [8192];
  logic [31:0] ref_mem [8192];

  rsp_t        q[$];
  bit          last_m1_m;
  logic [15:0] cnt_m [2];
  int          n_chk;
  int          n_fail;
  logic        obs_g1, obs_rv0, obs_rv1;
  logic [31:0] obs_rd0, obs_rd1;

  sp_ram_arbiter #(
    .ADDR_WIDTH(15),
    .DATA_WIDTH(32)
  ) dut (
    .clk         (clk),
    .rstn_i      (rstn),
    .m0_req_i    (req[0]),
    .m0_gnt_o    (m0_gnt),
    .m0_addr_i   (addr[0]),
    .m0_we_i     (we[0]),
    .m0_be_i     (be[0]),
    .m0_wdata_i  (wd[0]),
    .m0_rvalid_o (m0_rv),
    .m0_rdata_o  (m0_rd),
    .m1_req_i    (req[1]),
    .m1_gnt_o    (m1_gnt),
    .m1_addr_i   (addr[1]),
    .m1_we_i     (we[1]),
    .m1_be_i     (be[1]),
    .m1_wdata_i  (wd[1]),
    .m1_rvalid_o (m1_rv),
    .m1_rdata_o  (m1_rd),
    .ram_en_o    (ram_en),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_rdata_i (ram_rdata),
    .m0_gnt_cnt_o(cnt0),
    .m1_gnt_cnt_o(cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  // RAM model: registered read, garbage on write/idle
  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b])
          ram_mem[ram_addr[14:2]][8*b+:8] <= ram_wdata[8*b+:8];
      ram_rdata <= 32'hBAD0_BAD0;
    end else if (ram_en) begin
      ram_rdata <= ram_mem[ram_addr[14:2]];
    end else begin
      ram_rdata <= 32'h5A5A_5A5A;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr_next();
    for (int i = 0; i < 2; i++) begin
      nreq[i]  = 1'b0;
      nwe[i]   = 1'b0;
      naddr[i] = '0;
      nbe[i]   = '0;
      nwd[i]   = '0;
    end
  endtask

  task automatic clr_drive();
    for (int i = 0; i < 2; i++) begin
      req[i]  = 1'b0;
      we[i]   = 1'b0;
      addr[i] = '0;
      be[i]   = '0;
      wd[i]   = '0;
    end
  endtask

  task automatic model_reset();
    last_m1_m = 1'b0;
    cnt_m[0]  = '0;
    cnt_m[1]  = '0;
    q.delete();
  endtask

  task automatic step();
    logic  eg0, eg1;
    int    w;
    rsp_t  r;
    logic  erv [2];
    logic [31:0] erd [2];
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      req[i]  = nreq[i];
      we[i]   = nwe[i];
      addr[i] = naddr[i];
      be[i]   = nbe[i];
      wd[i]   = nwd[i];
    end
    #1;
    eg1 = req[1] && (!req[0] || !last_m1_m);
    eg0 = req[0] && !eg1;
    w   = eg1 ? 1 : 0;
    chk("gnt0", 32'(m0_gnt), 32'(eg0));
    chk("gnt1", 32'(m1_gnt), 32'(eg1));
    chk("ram_en", 32'(ram_en), 32'(eg0 | eg1));
    if (eg0 || eg1) begin
      chk("ram_addr", 32'(ram_addr), 32'(addr[w]));
      chk("ram_we", 32'(ram_we), 32'(we[w]));
      chk("ram_be", 32'(ram_be), 32'(be[w]));
      chk("ram_wdata", ram_wdata, wd[w]);
    end else begin
      chk("idle_ram", {ram_addr, ram_be, ram_we},
          32'd0);
      chk("idle_wdata", ram_wdata, 32'd0);
    end
    erv[0] = 1'b0; erv[1] = 1'b0;
    erd[0] = '0;   erd[1] = '0;
    if (q.size() > 0) begin
      r = q.pop_front();
      erv[r.own] = 1'b1;
      erd[r.own] = r.wr ? 32'd0 : r.data;
    end
    chk("rvalid0", 32'(m0_rv), 32'(erv[0]));
    chk("rvalid1", 32'(m1_rv), 32'(erv[1]));
    chk("rdata0", m0_rd, erd[0]);
    chk("rdata1", m1_rd, erd[1]);
    chk("cnt0", 32'(cnt0), 32'(cnt_m[0]));
    chk("cnt1", 32'(cnt1), 32'(cnt_m[1]));
    obs_g1  = m1_gnt;
    obs_rv0 = m0_rv;
    obs_rv1 = m1_rv;
    obs_rd0 = m0_rd;
    obs_rd1 = m1_rd;
    if (eg0 || eg1) begin
      r.own  = eg1;
      r.wr   = we[w];
      r.data = ref_mem[addr[w][14:2]];
      q.push_back(r);
      if (we[w])
        for (int b = 0; b < 4; b++)
          if (be[w][b])
            ref_mem[addr[w][14:2]][8*b+:8] = wd[w][8*b+:8];
      if (cnt_m[w] != 16'hFFFF)
        cnt_m[w] = cnt_m[w] + 16'd1;
      last_m1_m = eg1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    clr_next();
    clr_drive();
    #1;
    chk("rst_rv", {30'd0, m0_rv, m1_rv}, 32'd0);
    chk("rst_rd0", m0_rd, 32'd0);
    chk("rst_rd1", m1_rd, 32'd0);
    chk("rst_cnt", {cnt0, cnt1}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic set_m(input int m, input logic w,
                       input logic [14:0] a,
                       input logic [3:0] b,
                       input logic [31:0] d);
    nreq[m]  = 1'b1;
    nwe[m]   = w;
    naddr[m] = a;
    nbe[m]   = b;
    nwd[m]   = d;
  endtask

  logic tie_g1 [4];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rstn   = 1'b0;
    for (int i = 0; i < 8192; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    clr_next();
    clr_drive();
    model_reset();
    apply_reset();

    // single master write then read
    set_m(0, 1'b1, 15'h0040, 4'hF, 32'hDEADBEEF);
    step();
    set_m(0, 1'b0, 15'h0040, 4'hF, 32'h0);
    step();
    clr_next();
    step();
    chk("sm_rvalid", 32'(obs_rv0), 32'd1);
    chk("sm_rdata", obs_rd0, 32'hDEADBEEF);

    // tie after reset
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      set_m(0, 1'b0, 15'h0040, 4'hF, 32'h0);
      set_m(1, 1'b0, 15'h0044, 4'hF, 32'h0);
      step();
      tie_g1[k] = obs_g1;
    end
    clr_next();
    step();
    chk("tie_g_0", 32'(tie_g1[0]), 32'd1);
    chk("tie_g_1", 32'(tie_g1[1]), 32'd0);
    chk("tie_g_2", 32'(tie_g1[2]), 32'd1);
    chk("tie_g_3", 32'(tie_g1[3]), 32'd0);
    chk("tie_cnt0", 32'(cnt0), 32'd2);
    chk("tie_cnt1", 32'(cnt1), 32'd2);

    // partial write by m1
    set_m(1, 1'b1, 15'h0100, 4'b0101, 32'hAABBCCDD);
    step();
    set_m(1, 1'b0, 15'h0100, 4'hF, 32'h0);
    step();
    clr_next();
    step();
    chk("pw_rdata", obs_rd1, 32'h00BB00DD);

    // write response returns zero data
    set_m(0, 1'b1, 15'h0200, 4'hF, 32'h12345678);
    step();
    clr_next();
    step();
    chk("wr_rvalid", 32'(obs_rv0), 32'd1);
    chk("wr_rdata", obs_rd0, 32'd0);

    // random mixed traffic
    for (int k = 0; k < 300; k++) begin
      for (int m = 0; m < 2; m++) begin
        nreq[m]  = 1'($urandom_range(0, 1));
        nwe[m]   = 1'($urandom_range(0, 1));
        naddr[m] = 15'($urandom_range(0, 15) * 4);
        nbe[m]   = 4'($urandom_range(0, 15));
        nwd[m]   = $urandom;
      end
      step();
    end
    clr_next();
    step();

    // reset during an in-flight read response
    set_m(0, 1'b0, 15'h0040, 4'hF, 32'h0);
    step();
    clr_next();
    @(posedge clk);
    #2;
    chk("mid_rv_pre", 32'(m0_rv), 32'd1);
    chk("mid_rd_pre", m0_rd, 32'hDEADBEEF);
    rstn = 1'b0;
    clr_drive();
    #1;
    chk("mid_rv_rst", 32'(m0_rv), 32'd0);
    chk("mid_rd_rst", m0_rd, 32'd0);
    chk("mid_cnt_rst", {cnt0, cnt1}, 32'd0);
    model_reset();
    req[1] = 1'b1;
    #1;
    chk("rst_comb_gnt", 32'(m1_gnt), 32'd1);
    chk("rst_comb_en", 32'(ram_en), 32'd1);
    req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_rv", {30'd0, obs_rv0, obs_rv1}, 32'd0);
    end

    // counter saturation
    apply_reset();
    set_m(0, 1'b0, 15'h0000, 4'hF, 32'h0);
    for (int k = 0; k < 65540; k++)
      step();
    clr_next();
    step();
    chk("sat_cnt0", 32'(cnt0), 32'h0000FFFF);
    chk("sat_cnt1", 32'(cnt1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
